// File: rtl/fwd_hazard_unit_pkg.sv
// Shared select codes and multdiv FSM encodings for the forwarding/hazard unit.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    BYP_XM = 2'd0,
    BYP_MW = 2'd1,
    BYP_RF = 2'd2,
    BYP_MD = 2'd3
  } byp_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Pipeline-side bundle for the forwarding/hazard unit: DX/FD sources, stage dests, controls.
interface fwd_hazard_unit_if #(
  parameter int REG_BITS = 5,
  parameter int NUM_SRC  = 2
);
  logic [NUM_SRC*REG_BITS-1:0] dx_rs;
  logic [NUM_SRC-1:0]          dx_src_vld;
  logic [NUM_SRC*REG_BITS-1:0] fd_rs;
  logic [NUM_SRC-1:0]          fd_src_vld;
  logic [REG_BITS-1:0]         dx_rd;
  logic                        dx_mem_to_reg;
  logic [REG_BITS-1:0]         xm_rd;
  logic [REG_BITS-1:0]         mw_rd;
  logic                        xm_rwe;
  logic                        mw_rwe;
  logic                        flush;
  logic                        md_start;
  logic [REG_BITS-1:0]         md_rd;
  logic [2*NUM_SRC-1:0]        byp_sel;
  logic                        stall_fd;
  logic                        bubble_dx;
  logic                        md_busy;
  logic                        md_wb_en;

  modport master (
    output dx_rs, dx_src_vld, fd_rs, fd_src_vld, dx_rd, dx_mem_to_reg,
           xm_rd, mw_rd, xm_rwe, mw_rwe, flush, md_start, md_rd,
    input  byp_sel, stall_fd, bubble_dx, md_busy, md_wb_en
  );

  modport slave (
    input  dx_rs, dx_src_vld, fd_rs, fd_src_vld, dx_rd, dx_mem_to_reg,
           xm_rd, mw_rd, xm_rwe, mw_rwe, flush, md_start, md_rd,
    output byp_sel, stall_fd, bubble_dx, md_busy, md_wb_en
  );
endinterface

// File: rtl/fwd_hazard_unit_src_match.sv
// One source-vs-destination compare; $0 never matches so it is never forwarded or stalled on.
module fwd_hazard_unit_src_match #(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] i_rs,
  input  logic                i_rs_vld,
  input  logic [REG_BITS-1:0] i_rd,
  input  logic                i_we,
  output logic                o_hit
);
  assign o_hit = i_rs_vld & i_we & (i_rs != '0) & (i_rs == i_rd);
endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand bypass select, load-use / scoreboard / structural stalls and multdiv tracking FSM.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_BITS = 5,
  parameter int NUM_SRC  = 2,
  parameter int MD_LAT   = 32
) (
  input logic              clock,
  input logic              reset_n,
  fwd_hazard_unit_if.slave bus
);
  localparam int CNT_W = $clog2(MD_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [REG_BITS-1:0] r_md_rd, w_md_rd_nxt;
  logic                w_run, w_done;

  logic [NUM_SRC-1:0]      w_xm_hit, w_mw_hit, w_md_hit, w_ld_hit, w_sb_hit;
  logic [NUM_SRC-1:0][1:0] w_sel;
  logic                    w_ld_use, w_sb_stall, w_struct;

  assign w_run  = (r_state == MD_RUN);
  assign w_done = (r_state == MD_DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_md_rd <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_md_rd <= w_md_rd_nxt;
    end
  end

  // DONE accepts a new start directly so back-to-back ops lose no cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_rd_nxt = r_md_rd;
    case (r_state)
      MD_IDLE, MD_DONE: begin
        if (bus.md_start) begin
          w_state_nxt = MD_RUN;
          w_cnt_nxt   = CNT_LOAD;
          w_md_rd_nxt = bus.md_rd;
        end else begin
          w_state_nxt = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (r_cnt <= CNT_ONE) w_state_nxt = MD_DONE;
        else                  w_cnt_nxt   = r_cnt - CNT_ONE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_ch
    logic [REG_BITS-1:0] w_dx_rs, w_fd_rs;
    assign w_dx_rs = bus.dx_rs[i*REG_BITS +: REG_BITS];
    assign w_fd_rs = bus.fd_rs[i*REG_BITS +: REG_BITS];

    fwd_hazard_unit_src_match #(.REG_BITS(REG_BITS)) u_xm (
      .i_rs(w_dx_rs), .i_rs_vld(bus.dx_src_vld[i]), .i_rd(bus.xm_rd),
      .i_we(bus.xm_rwe), .o_hit(w_xm_hit[i]));
    fwd_hazard_unit_src_match #(.REG_BITS(REG_BITS)) u_mw (
      .i_rs(w_dx_rs), .i_rs_vld(bus.dx_src_vld[i]), .i_rd(bus.mw_rd),
      .i_we(bus.mw_rwe), .o_hit(w_mw_hit[i]));
    fwd_hazard_unit_src_match #(.REG_BITS(REG_BITS)) u_md (
      .i_rs(w_dx_rs), .i_rs_vld(bus.dx_src_vld[i]), .i_rd(r_md_rd),
      .i_we(w_done), .o_hit(w_md_hit[i]));
    fwd_hazard_unit_src_match #(.REG_BITS(REG_BITS)) u_ld (
      .i_rs(w_fd_rs), .i_rs_vld(bus.fd_src_vld[i]), .i_rd(bus.dx_rd),
      .i_we(bus.dx_mem_to_reg), .o_hit(w_ld_hit[i]));
    fwd_hazard_unit_src_match #(.REG_BITS(REG_BITS)) u_sb (
      .i_rs(w_fd_rs), .i_rs_vld(bus.fd_src_vld[i]), .i_rd(r_md_rd),
      .i_we(w_run), .o_hit(w_sb_hit[i]));

    assign w_sel[i] = !reset_n    ? BYP_RF :
                      w_md_hit[i] ? BYP_MD :
                      w_xm_hit[i] ? BYP_XM :
                      w_mw_hit[i] ? BYP_MW : BYP_RF;
  end

  assign bus.byp_sel = w_sel;

  // A flushed FD never executes, so its load-use dependency is moot.
  assign w_ld_use   = (|w_ld_hit) & ~bus.flush;
  assign w_sb_stall = |w_sb_hit;
  assign w_struct   = w_run & bus.md_start;

  assign bus.stall_fd  = reset_n & (w_ld_use | w_sb_stall | w_struct);
  assign bus.bubble_dx = reset_n & (w_ld_use | w_sb_stall);
  assign bus.md_busy   = reset_n & w_run;
  assign bus.md_wb_en  = reset_n & w_done;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed + random bench for fwd_hazard_unit against a cycle-timestamp reference model.
module tb_fwd_hazard_unit;
  localparam int RB  = 5;
  localparam int NS  = 2;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  fwd_hazard_unit_if #(.REG_BITS(RB), .NUM_SRC(NS)) bus ();

  fwd_hazard_unit #(.REG_BITS(RB), .NUM_SRC(NS), .MD_LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus));

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: an accepted op issued in cycle t0 is busy in (t0, t0+LAT) and writes back at t0+LAT.
  bit              m_act = 1'b0;
  int              m_t0  = 0;
  logic [RB-1:0]   m_rd  = '0;

  function automatic bit m_running();
    return m_act && (cyc - m_t0) >= 1 && (cyc - m_t0) < LAT;
  endfunction

  function automatic bit m_done();
    return m_act && (cyc - m_t0) == LAT;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic clr();
    bus.dx_rs = '0; bus.dx_src_vld = '0; bus.fd_rs = '0; bus.fd_src_vld = '0;
    bus.dx_rd = '0; bus.dx_mem_to_reg = 1'b0; bus.xm_rd = '0; bus.mw_rd = '0;
    bus.xm_rwe = 1'b0; bus.mw_rwe = 1'b0; bus.flush = 1'b0;
    bus.md_start = 1'b0; bus.md_rd = '0;
  endtask

  // Sample at negedge and compare every output with the model.
  task automatic eval();
    logic [RB-1:0]   r, f;
    logic [2*NS-1:0] es;
    bit ld, sb, run, done, rst;
    @(negedge clock);
    run = m_running(); done = m_done(); rst = reset_n;
    ld = 1'b0; sb = 1'b0; es = '0;
    for (int i = 0; i < NS; i++) begin
      r = bus.dx_rs[i*RB +: RB];
      f = bus.fd_rs[i*RB +: RB];
      if (!rst || !bus.dx_src_vld[i] || r == 0)  es[2*i +: 2] = 2'd2;
      else if (done && r == m_rd)               es[2*i +: 2] = 2'd3;
      else if (bus.xm_rwe && r == bus.xm_rd)    es[2*i +: 2] = 2'd0;
      else if (bus.mw_rwe && r == bus.mw_rd)    es[2*i +: 2] = 2'd1;
      else                                      es[2*i +: 2] = 2'd2;
      if (bus.fd_src_vld[i] && f != 0 && f == bus.dx_rd && bus.dx_mem_to_reg) ld = 1'b1;
      if (bus.fd_src_vld[i] && f != 0 && f == m_rd && run) sb = 1'b1;
    end
    if (bus.flush) ld = 1'b0;
    check("byp_sel",   8'(bus.byp_sel),   8'(es));
    check("stall_fd",  8'(bus.stall_fd),  8'(rst && (ld || sb || (run && bus.md_start))));
    check("bubble_dx", 8'(bus.bubble_dx), 8'(rst && (ld || sb)));
    check("md_busy",   8'(bus.md_busy),   8'(rst && run));
    check("md_wb_en",  8'(bus.md_wb_en),  8'(rst && done));
  endtask

  task automatic adv();
    bit done;
    @(posedge clock);
    done = m_done();
    if (!reset_n) m_act = 1'b0;
    else if (bus.md_start && (!m_act || done)) begin
      m_act = 1'b1; m_t0 = cyc; m_rd = bus.md_rd;
    end else if (done) m_act = 1'b0;
    cyc++;
    #1;
  endtask

  task automatic step();
    eval();
    adv();
  endtask

  initial begin
    clr();
    // Reset: outputs forced regardless of inputs.
    reset_n = 1'b0;
    bus.xm_rwe = 1'b1; bus.xm_rd = 5; bus.dx_rs = {5'd5, 5'd5}; bus.dx_src_vld = 2'b11;
    bus.md_start = 1'b1; bus.md_rd = 6;
    eval(); check("rst_sel", 8'(bus.byp_sel), 8'h0a); adv();
    step();
    reset_n = 1'b1; clr(); step();

    // XM beats MW; $0 always from RF.
    bus.xm_rwe = 1'b1; bus.xm_rd = 5; bus.mw_rwe = 1'b1; bus.mw_rd = 5;
    bus.dx_rs = {5'd0, 5'd5}; bus.dx_src_vld = 2'b11;
    eval(); check("xm_win", 8'(bus.byp_sel), 8'h08); adv();
    bus.xm_rwe = 1'b0; bus.xm_rd = 7; bus.mw_rd = 7; bus.dx_rs = {5'd7, 5'd7};
    eval(); check("mw_fwd", 8'(bus.byp_sel), 8'h05); adv();
    bus.mw_rwe = 1'b0;
    eval(); check("rf_sel", 8'(bus.byp_sel), 8'h0a); adv();

    // Load-use, then the same with flush.
    clr(); bus.dx_mem_to_reg = 1'b1; bus.dx_rd = 3;
    bus.fd_rs = {5'd1, 5'd3}; bus.fd_src_vld = 2'b11;
    eval(); check("ld_stall", 8'({bus.stall_fd, bus.bubble_dx}), 8'h3); adv();
    bus.flush = 1'b1;
    eval(); check("ld_flush", 8'({bus.stall_fd, bus.bubble_dx}), 8'h0); adv();

    // Multdiv rd=9: busy t1..t3, scoreboard stall t2, writeback + MD forward t4.
    clr(); bus.md_start = 1'b1; bus.md_rd = 9; step();
    bus.md_start = 1'b0;
    eval(); check("md_busy_t1", 8'(bus.md_busy), 8'h1); adv();
    bus.fd_rs = {5'd0, 5'd9}; bus.fd_src_vld = 2'b01;
    eval(); check("sb_stall", 8'({bus.stall_fd, bus.bubble_dx}), 8'h3); adv();
    clr(); step();
    bus.dx_rs = {5'd0, 5'd9}; bus.dx_src_vld = 2'b11;
    eval(); check("md_fwd", 8'(bus.byp_sel), 8'h0b); check("md_wb", 8'(bus.md_wb_en), 8'h1); adv();
    clr(); step();

    // Structural hazard: second start held from t2, accepted in DONE at t4.
    bus.md_start = 1'b1; bus.md_rd = 10; step();
    bus.md_start = 1'b0; step();
    bus.md_start = 1'b1; bus.md_rd = 11;
    eval(); check("struct", 8'({bus.stall_fd, bus.bubble_dx}), 8'h2); adv();
    step();
    eval(); check("b2b_wb", 8'(bus.md_wb_en), 8'h1); adv();
    bus.md_start = 1'b0;
    eval(); check("b2b_busy", 8'(bus.md_busy), 8'h1); adv();
    for (int k = 0; k < 5; k++) step();

    // Reset mid-run aborts the op.
    bus.md_start = 1'b1; bus.md_rd = 12; step();
    bus.md_start = 1'b0; step();
    reset_n = 1'b0; bus.xm_rwe = 1'b1; bus.xm_rd = 12;
    bus.dx_rs = {5'd12, 5'd12}; bus.dx_src_vld = 2'b11;
    eval(); check("rst_mid_sel", 8'(bus.byp_sel), 8'h0a); adv();
    reset_n = 1'b1; clr();
    eval(); check("rst_mid_busy", 8'(bus.md_busy), 8'h0); adv();
    for (int k = 0; k < 4; k++) begin
      eval(); check("rst_no_wb", 8'(bus.md_wb_en), 8'h0); adv();
    end

    // Random traffic against the model.
    for (int k = 0; k < 600; k++) begin
      reset_n           = ($urandom_range(0, 59) != 0);
      bus.dx_rs         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.dx_src_vld    = 2'($urandom_range(0, 3));
      bus.fd_rs         = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.fd_src_vld    = 2'($urandom_range(0, 3));
      bus.dx_rd         = 5'($urandom_range(0, 7));
      bus.dx_mem_to_reg = ($urandom_range(0, 3) == 0);
      bus.xm_rd         = 5'($urandom_range(0, 7));
      bus.mw_rd         = 5'($urandom_range(0, 7));
      bus.xm_rwe        = 1'($urandom_range(0, 1));
      bus.mw_rwe        = 1'($urandom_range(0, 1));
      bus.flush         = ($urandom_range(0, 7) == 0);
      bus.md_start      = ($urandom_range(0, 5) == 0);
      bus.md_rd         = 5'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
